obuf_pingpong: RTL and testbench
================================

// Module: obuf_pingpong
// PURPOSE
//   Parametrised multi-bank output buffer between the ppu write stream and the host/tb readback path.
//   Successor to the single flat output ram: NUM_BANKS tile banks rotate so the ppu fills one while a drained bank streams out via valid/ready.
//   Adds tile-boundary bank switching, back-pressure (stall), overflow flagging and sequential readback.
// PARAMETERS
//   VEC_WIDTH  64  bits per entry (INT4 x 16)
//   DEPTH      64  entries per bank (one full tile)
//   NUM_BANKS  2   number of rotating banks, >= 2
//   AW         13  width of incoming ppu write address; low $clog2(DEPTH) bits index the bank
// PORTS
//   i_clk        in   1          clock
//   i_rst_n      in   1          synchronous active-low reset
//   i_wr_en      in   1          ppu write strobe
//   i_wr_addr    in   AW         ppu write address
//   i_wr_data    in   VEC_WIDTH  ppu write data
//   i_tile_done  in   1          last write of current tile (may coincide with i_wr_en)
//   o_wr_stall   out  1          next write bank not empty; ppu must hold writes
//   o_overflow   out  1          sticky: write dropped (stalled or addr >= DEPTH)
//   o_rd_valid   out  1          readback beat valid
//   o_rd_data    out  VEC_WIDTH  readback data
//   o_rd_addr    out  $clog2(DEPTH)  entry index of o_rd_data
//   o_rd_last    out  1          beat is entry DEPTH-1 of its bank
//   i_rd_ready   in   1          consumer accepts beat
//   o_busy       out  1          any bank not EMPTY
// BEHAVIOUR
//   - Reset (sync, active-low; aborts any fill/drain): all banks EMPTY, wr_ptr=rd_ptr=0, rd_cnt=0;
//     outputs o_wr_stall=0, o_overflow=0, o_rd_valid=0, o_rd_data=0, o_rd_addr=0, o_rd_last=0, o_busy=0. Storage not cleared.
//   - Per-bank state: EMPTY -> FILLING (first accepted write) -> FULL (i_tile_done) -> DRAINING (first beat loaded) -> EMPTY (last beat accepted).
//   - Write accepted when i_wr_en & !o_wr_stall & addr < DEPTH: bank[wr_ptr][addr] <= data. Otherwise dropped, o_overflow <= 1 (sticky until reset).
//   - i_tile_done with wr_ptr bank EMPTY/FILLING: bank -> FULL, wr_ptr <= (wr_ptr+1) mod NUM_BANKS. Same-cycle write lands in the old bank first.
//     i_tile_done while stalled: ignored.
//   - o_wr_stall registered: 1 when bank[wr_ptr] is FULL or DRAINING. Deasserts the cycle after that bank returns to EMPTY.
//   - Readback: output register loads when (!o_rd_valid | i_rd_ready) and bank[rd_ptr] FULL/DRAINING with beats remaining.
//     Loads o_rd_data=bank[rd_ptr][rd_cnt], o_rd_addr=rd_cnt, o_rd_last=(rd_cnt==DEPTH-1); then rd_cnt++.
//   - Latency: FULL transition at edge N -> o_rd_valid at edge N+1. Throughput 1 beat/cycle while i_rd_ready=1.
//   - o_rd_valid/data/addr/last held stable while i_rd_ready=0.
//   - Last beat accepted: bank -> EMPTY, rd_cnt <= 0, rd_ptr advances mod NUM_BANKS.
//     Next FULL bank's first beat may load in the same cycle (no bubble).
//   - Simultaneous tile_done into a bank and drain completion of another: both apply; stall recomputed next cycle.
//   - Unwritten entries of a partially written tile are read back as stored (see CONFIGURATION).
//   - o_busy = OR of (bank state != EMPTY), registered.
// CONFIGURATION
//   OBUF_CLR_ON_DRAIN_EN defined: each entry written to 0 when its beat is loaded into the output register.
//     A partial tile then reads 0 in unwritten slots.
//   Undefined: storage retains stale data; no extra write port logic.
// TESTING
//   1. Write addr 0..63 data=addr, tile_done on addr 63, ready=1 -> 64 beats data 0..63, last on 63, o_busy=0 after.
//   2. Hold ready=0, fill bank0 and bank1 -> o_wr_stall=1; extra write sets o_overflow=1, bank contents unchanged.
//      Ready=1 -> bank0 drains, stall drops 1 cycle after bank0 EMPTY.
//   3. Write addr 64 -> dropped, o_overflow=1; addr 5 written normally in same tile.
//   4. Toggle i_rd_ready 1010... -> each beat held while ready=0, no beat duplicated or skipped, order 0..63.
//   5. Two tiles back-to-back, ready=1 -> 128 beats with no bubble between bank0 last and bank1 entry 0.
//   6. Reset mid-drain at beat 20 -> next cycle o_rd_valid=0, o_busy=0, stall=0.
//      With OBUF_CLR_ON_DRAIN_EN: tile writing only addr 3 after a full tile reads 0 except entry 3.

Source files
------------

// File: rtl/obuf_pingpong.sv
// Rotating multi-bank output buffer: ppu fills one bank while a sealed bank streams out via valid/ready.
// Optional OBUF_CLR_ON_DRAIN_EN: zero each entry as its beat is loaded, so partial tiles read 0 in unwritten slots.
//
// bank state  | meaning
// ST_EMPTY    | no data, free for the ppu
// ST_FILLING  | at least one write accepted, tile not yet closed
// ST_FULL     | tile closed, waiting for readback to start
// ST_DRAINING | readback in progress, at least one beat loaded
module obuf_pingpong #(
  parameter int VEC_WIDTH = 64,
  parameter int DEPTH     = 64,
  parameter int NUM_BANKS = 2,
  parameter int AW        = 13
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr_en,
  input  logic [AW-1:0]            i_wr_addr,
  input  logic [VEC_WIDTH-1:0]     i_wr_data,
  input  logic                     i_tile_done,
  output logic                     o_wr_stall,
  output logic                     o_overflow,
  output logic                     o_rd_valid,
  output logic [VEC_WIDTH-1:0]     o_rd_data,
  output logic [$clog2(DEPTH)-1:0] o_rd_addr,
  output logic                     o_rd_last,
  input  logic                     i_rd_ready,
  output logic                     o_busy
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = $clog2(NUM_BANKS);
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILLING,
    ST_FULL,
    ST_DRAINING
  } bank_st_e;

  bank_st_e             st_q [NUM_BANKS];
  bank_st_e             st_d [NUM_BANKS];
  logic [VEC_WIDTH-1:0] mem_q [NUM_BANKS][DEPTH];

  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        rd_cnt_q, rd_cnt_d;
  logic                 wr_stall_q, wr_stall_d;
  logic                 overflow_q, overflow_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [VEC_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [IW-1:0]        rd_addr_q, rd_addr_d;
  logic                 rd_last_q, rd_last_d;
  logic                 busy_q, busy_d;

  logic                 wr_ok, td_ok, last_acc, load;
  logic [PW-1:0]        src_ptr;
  logic [CW-1:0]        src_cnt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NUM_BANKS - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic is_sealed(input bank_st_e s);
    return (s == ST_FULL) || (s == ST_DRAINING);
  endfunction

  always_comb begin
    wr_ok    = i_wr_en & ~wr_stall_q & (i_wr_addr < AW'(DEPTH));
    td_ok    = i_tile_done & ~wr_stall_q & ~is_sealed(st_q[wr_ptr_q]);
    last_acc = rd_valid_q & i_rd_ready & rd_last_q;
    // On the last accepted beat the next bank's first beat is fetched in the same cycle
    src_ptr  = last_acc ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    src_cnt  = last_acc ? '0 : rd_cnt_q;
    load     = (~rd_valid_q | i_rd_ready) &
               ((st_q[src_ptr] == ST_FULL) |
                ((st_q[src_ptr] == ST_DRAINING) & (src_cnt < CW'(DEPTH))));

    for (int b = 0; b < NUM_BANKS; b++) st_d[b] = st_q[b];
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_cnt_d   = rd_cnt_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    rd_addr_d  = rd_addr_q;
    rd_last_d  = rd_last_q;
    overflow_d = overflow_q | (i_wr_en & ~wr_ok);

    if (wr_ok && st_q[wr_ptr_q] == ST_EMPTY) st_d[wr_ptr_q] = ST_FILLING;
    if (td_ok) begin
      st_d[wr_ptr_q] = ST_FULL;
      wr_ptr_d       = ptr_inc(wr_ptr_q);
    end

    if (last_acc) begin
      st_d[rd_ptr_q] = ST_EMPTY;
      rd_ptr_d       = ptr_inc(rd_ptr_q);
      rd_cnt_d       = '0;
    end

    if (load) begin
      if (st_q[src_ptr] == ST_FULL) st_d[src_ptr] = ST_DRAINING;
      rd_valid_d = 1'b1;
      rd_data_d  = mem_q[src_ptr][src_cnt[IW-1:0]];
      rd_addr_d  = src_cnt[IW-1:0];
      rd_last_d  = (src_cnt == CW'(DEPTH - 1));
      rd_cnt_d   = src_cnt + CW'(1);
    end else if (i_rd_ready) begin
      rd_valid_d = 1'b0;
    end

    // Stall follows the current write bank one cycle late, but engages at once when
    // closing a tile rotates the pointer onto a bank that is still sealed
    wr_stall_d = is_sealed(st_q[wr_ptr_q]) | (td_ok & is_sealed(st_d[wr_ptr_d]));

    busy_d = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) busy_d = busy_d | (st_d[b] != ST_EMPTY);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) st_q[b] <= ST_EMPTY;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_cnt_q   <= '0;
      wr_stall_q <= 1'b0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_addr_q  <= '0;
      rd_last_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) st_q[b] <= st_d[b];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_stall_q <= wr_stall_d;
      overflow_q <= overflow_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_addr_q  <= rd_addr_d;
      rd_last_q  <= rd_last_d;
      busy_q     <= busy_d;
    end
  end

  // Storage is deliberately left out of reset
  always_ff @(posedge i_clk) begin
    if (i_rst_n && wr_ok) mem_q[wr_ptr_q][i_wr_addr[IW-1:0]] <= i_wr_data;
`ifdef OBUF_CLR_ON_DRAIN_EN
    if (i_rst_n && load) mem_q[src_ptr][src_cnt[IW-1:0]] <= '0;
`else
`endif
  end

  assign o_wr_stall = wr_stall_q;
  assign o_overflow = overflow_q;
  assign o_rd_valid = rd_valid_q;
  assign o_rd_data  = rd_data_q;
  assign o_rd_addr  = rd_addr_q;
  assign o_rd_last  = rd_last_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_obuf_pingpong.sv
// Randomised bench for obuf_pingpong against a tile-queue reference model.
module tb_obuf_pingpong;
  localparam int VW = 64, DEPTH = 64, NB = 2, AW = 13, IW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, wr_en, tile_done, rd_ready;
  logic [AW-1:0] wr_addr;
  logic [VW-1:0] wr_data;
  logic          wr_stall, overflow, rd_valid, rd_last, busy;
  logic [VW-1:0] rd_data;
  logic [IW-1:0] rd_addr;

  obuf_pingpong #(.VEC_WIDTH(VW), .DEPTH(DEPTH), .NUM_BANKS(NB), .AW(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_tile_done(tile_done), .o_wr_stall(wr_stall),
    .o_overflow(overflow), .o_rd_valid(rd_valid), .o_rd_data(rd_data),
    .o_rd_addr(rd_addr), .o_rd_last(rd_last), .i_rd_ready(rd_ready), .o_busy(busy)
  );

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: closed tiles become a queue of expected beats
  typedef struct {
    logic [VW-1:0] d;
    int            a;
    int            b;
  } beat_t;

  beat_t         q[$];
  beat_t         m_cur;
  logic [VW-1:0] m_mem [NB][DEPTH];
  logic          m_used [NB];
  logic          m_sealed [NB];
  logic          m_valid, m_stall, m_ovf, m_busy;
  int            m_wr;
  int            acc_cnt = 0;

  int   rdy_mode = 0;
  logic rdy_fix = 1'b0;
  logic rdy_tgl = 1'b0;

  task automatic model_update();
    logic sealed_pre [NB];
    int   wr_pre;
    logic pre_stall, wr_ok, td_ok;
    beat_t bt;
    if (!rst_n) begin
      q.delete();
      m_valid = 1'b0;
      m_cur.d = '0; m_cur.a = 0; m_cur.b = 0;
      for (int b = 0; b < NB; b++) begin m_used[b] = 1'b0; m_sealed[b] = 1'b0; end
      m_wr = 0; m_stall = 1'b0; m_ovf = 1'b0; m_busy = 1'b0;
      return;
    end
    for (int b = 0; b < NB; b++) sealed_pre[b] = m_sealed[b];
    wr_pre    = m_wr;
    pre_stall = m_stall;

    if (m_valid && rd_ready) begin
      acc_cnt++;
      if (m_cur.a == DEPTH - 1) begin
        m_sealed[m_cur.b] = 1'b0;
        m_used[m_cur.b]   = 1'b0;
      end
    end
    if (!m_valid || rd_ready) begin
      if (q.size() > 0) begin
        m_cur   = q.pop_front();
        m_valid = 1'b1;
`ifdef OBUF_CLR_ON_DRAIN_EN
        m_mem[m_cur.b][m_cur.a] = '0;
`else
`endif
      end else begin
        m_valid = 1'b0;
      end
    end

    wr_ok = wr_en && !pre_stall && (wr_addr < DEPTH);
    td_ok = tile_done && !pre_stall;
    if (wr_en && !wr_ok) m_ovf = 1'b1;
    if (wr_ok) begin
      m_mem[wr_pre][wr_addr[IW-1:0]] = wr_data;
      m_used[wr_pre] = 1'b1;
    end
    if (td_ok) begin
      m_sealed[wr_pre] = 1'b1;
      m_used[wr_pre]   = 1'b1;
      for (int a = 0; a < DEPTH; a++) begin
        bt.d = m_mem[wr_pre][a]; bt.a = a; bt.b = wr_pre;
        q.push_back(bt);
      end
      m_wr = (m_wr + 1) % NB;
    end
    m_stall = sealed_pre[wr_pre] || (td_ok && m_sealed[m_wr]);
    m_busy = 1'b0;
    for (int b = 0; b < NB; b++) m_busy = m_busy | m_used[b];
  endtask

  task automatic compare_all();
    chk("rd_valid", rd_valid, m_valid);
    if (m_valid) begin
      chk("rd_data", rd_data, m_cur.d);
      chk("rd_addr", rd_addr, m_cur.a);
      chk("rd_last", rd_last, m_cur.a == DEPTH - 1);
    end
    chk("wr_stall", wr_stall, m_stall);
    chk("overflow", overflow, m_ovf);
    chk("busy", busy, m_busy);
  endtask

  task automatic step();
    case (rdy_mode)
      0: rd_ready = rdy_fix;
      1: begin rd_ready = rdy_tgl; rdy_tgl = ~rdy_tgl; end
      default: rd_ready = 1'($urandom_range(0, 1));
    endcase
    model_update();
    @(posedge clk);
    #1;
    compare_all();
    wr_en     = 1'b0;
    tile_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_unstall();
    for (int i = 0; i < 1000 && m_stall; i++) step();
    if (m_stall) chk("unstall_timeout", wr_stall, 0);
  endtask

  task automatic ppu_tile(input int kind);
    for (int a = 0; a < DEPTH; a++) begin
      wait_unstall();
      wr_en     = 1'b1;
      wr_addr   = AW'(a);
      wr_data   = (kind == 0) ? VW'(a) : {$urandom, $urandom};
      tile_done = (a == DEPTH - 1);
      step();
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 2000 && m_busy; i++) step();
    step();
    chk(tag, busy, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int base;
    rst_n = 1'b0; wr_en = 1'b0; tile_done = 1'b0; rd_ready = 1'b0;
    wr_addr = '0; wr_data = '0;
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++) m_mem[b][a] = '0;
    do_reset();
    chk("rst_valid", rd_valid, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_last", rd_last, 0);
    chk("rst_stall", wr_stall, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);

    // Ramp tile with ready high, then a random tile to initialise bank 1
    rdy_mode = 0; rdy_fix = 1'b1;
    ppu_tile(0);
    ppu_tile(1);
    drain("t1_idle");

    // Both banks full under back-pressure, then a write that must be dropped
    rdy_fix = 1'b0;
    ppu_tile(1);
    ppu_tile(1);
    step();
    chk("t2_stall", wr_stall, 1);
    wr_en = 1'b1; wr_addr = AW'(7); wr_data = {$urandom, $urandom};
    step();
    chk("t2_ovf", overflow, 1);
    rdy_fix = 1'b1;
    drain("t2_idle");

    // Out-of-range address, then a one-entry tile over stale contents
    do_reset();
    wr_en = 1'b1; wr_addr = AW'(64); wr_data = {$urandom, $urandom};
    step();
    chk("t3_ovf", overflow, 1);
    wr_en = 1'b1; wr_addr = AW'(5); wr_data = {$urandom, $urandom}; tile_done = 1'b1;
    step();
    drain("t3_idle");

    // Alternating ready
    rdy_mode = 1;
    ppu_tile(0);
    drain("t4_idle");

    // Two tiles back to back
    rdy_mode = 0; rdy_fix = 1'b1;
    ppu_tile(1);
    ppu_tile(1);
    drain("t5_idle");

    // Reset while draining
    ppu_tile(0);
    base = acc_cnt;
    for (int i = 0; i < 200 && (acc_cnt - base) < 20; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6_valid", rd_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_stall", wr_stall, 0);

    // Single-entry tile after a full tile
    ppu_tile(1);
    wr_en = 1'b1; wr_addr = AW'(3); wr_data = {$urandom, $urandom}; tile_done = 1'b1;
    step();
    drain("t6b_idle");

    // Random traffic, including writes and tile_done while stalled
    rdy_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      if (!m_stall || $urandom_range(0, 15) == 0) begin
        wr_en   = ($urandom_range(0, 2) != 0);
        wr_addr = ($urandom_range(0, 19) == 0) ? AW'($urandom_range(64, 8191))
                                               : AW'($urandom_range(0, 63));
        wr_data = {$urandom, $urandom};
      end
      tile_done = ($urandom_range(0, 39) == 0);
      step();
    end
    rdy_mode = 0; rdy_fix = 1'b1;
    drain("rand_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
